mencode_tx: RTL and testbench

Manchester transmit framer: accepts parallel words over a valid/ready handshake and emits a serial Manchester half-symbol stream. It sits directly upstream of the `mdecode` receive stage, either across the link or in loopback, and uses the same symbol convention. A `1` is sent as half-symbols `1,0`; a `0` is sent as `0,1`. Each frame consists of a preamble, a start bit, the data word MSB-first, an optional even-parity bit, and an inter-frame gap.

---
 rtl/mcode_pkg.sv | 27 ++
 rtl/mhalf_tick.sv | 37 +++
 rtl/mencode_tx.sv | 149 ++++++++++++++
 tb/tb_mencode_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mcode_pkg.sv
// rtl/mcode_pkg.sv - shared Manchester state encodings, symbol constants and width helpers
package mcode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } mstate_t;

  // First half-symbol in bit 1, second half in bit 0.
  localparam logic [1:0] SYM1 = 2'b10;
  localparam logic [1:0] SYM0 = 2'b01;

  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mhalf_tick.sv
// rtl/mhalf_tick.sv - half-symbol strobe and phase generator
module mhalf_tick
  import mcode_pkg::*;
#(
  parameter int HALF_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic phase
);

  localparam int CW = clog2w(HALF_CYC);
  localparam logic [CW-1:0] LAST = CW'(HALF_CYC - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Held at phase 0 while disabled so every frame starts on a first half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mencode_tx.sv
// rtl/mencode_tx.sv - Manchester transmit framer: preamble, start, data MSB-first, parity, gap
module mencode_tx
  import mcode_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PRE_BITS = 8,
  parameter int HALF_CYC = 1,
  parameter int PARITY   = 1,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dataout,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BCW = clog2w(max3(PRE_BITS, DATA_W, GAP_BITS) + 1);
  localparam logic [BCW-1:0] PRE_LD  = BCW'(PRE_BITS - 1);
  localparam logic [BCW-1:0] DATA_LD = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] GAP_LD  = BCW'(GAP_BITS - 1);

  mstate_t           state, state_n;
  logic [BCW-1:0]    bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg;
  logic              par_q;
  logic              tick, phase, bit_end, last;
  logic              bitval, half;
  logic [1:0]        sym;

  mhalf_tick #(.HALF_CYC(HALF_CYC)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (state != ST_IDLE),
    .tick  (tick),
    .phase (phase)
  );

  assign bit_end  = tick & phase;
  assign last     = (bit_cnt == '0);
  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = (state != ST_IDLE);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    tx_done   = 1'b0;
    bitval    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          state_n   = ST_PRE;
          bit_cnt_n = PRE_LD;
        end
      end
      ST_PRE: begin
        bitval = 1'b1;
        if (bit_end) begin
          if (last) begin
            state_n   = ST_START;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt - 1'b1;
          end
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_n   = ST_DATA;
          bit_cnt_n = DATA_LD;
        end
      end
      ST_DATA: begin
        bitval = shreg[DATA_W-1];
        if (bit_end) begin
          if (!last) begin
            bit_cnt_n = bit_cnt - 1'b1;
          end else if (PARITY != 0) begin
            state_n   = ST_PAR;
            bit_cnt_n = '0;
          end else if (GAP_BITS != 0) begin
            state_n   = ST_GAP;
            bit_cnt_n = GAP_LD;
          end else begin
            state_n = ST_IDLE;
            tx_done = 1'b1;
          end
        end
      end
      ST_PAR: begin
        bitval = par_q;
        if (bit_end) begin
          if (GAP_BITS != 0) begin
            state_n   = ST_GAP;
            bit_cnt_n = GAP_LD;
          end else begin
            state_n = ST_IDLE;
            tx_done = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (last) begin
            state_n = ST_IDLE;
            tx_done = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt - 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign sym  = bitval ? SYM1 : SYM0;
  assign half = phase ? sym[0] : sym[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      par_q   <= 1'b0;
      dataout <= 1'b0;
    end else begin
      if (state == ST_IDLE && tx_valid) begin
        shreg <= tx_data;
        par_q <= ^tx_data;
      end else if (state == ST_DATA && bit_end) begin
        shreg <= shreg << 1;
      end
      // Line sits at the idle level outside the active part of a frame.
      dataout <= (state == ST_IDLE || state == ST_GAP) ? 1'b0 : half;
    end
  end

endmodule

// File: tb/tb_mencode_tx.sv
// tb/tb_mencode_tx.sv - scoreboard bench for mencode_tx with a frame-level reference model
module tb_mencode_tx;

  localparam int DW    = 8;
  localparam int PB    = 8;
  localparam int HC    = 3;
  localparam int PAR   = 1;
  localparam int GB    = 2;
  localparam int NBITS = PB + 1 + DW + PAR;
  localparam int LINE  = 2 * NBITS * HC;
  localparam int GAPC  = 2 * GB * HC;
  localparam int TOTAL = LINE + GAPC;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready, dataout, tx_busy, tx_done;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] exp_q[$];
  bit            mon_active = 1'b0;

  mencode_tx #(
    .DATA_W(DW), .PRE_BITS(PB), .HALF_CYC(HC), .PARITY(PAR), .GAP_BITS(GB)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .dataout(dataout), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: builds the expected line from the frame rules and compares sample by sample.
  initial begin : monitor
    logic          exp_bits[$];
    logic          samp[$];
    logic          bq[$];
    logic [DW-1:0] w, dec;
    int            idx, nmis, first_bad, done_bad, rb_bad;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        mon_active = 1'b0;
        continue;
      end
      if (!mon_active) begin
        if (tx_done === 1'b1) begin
          checks++; errors++;
          $display("FAIL spurious_done at cycle %0d actual=1 required=0", cyc);
        end
        if (dataout === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame at cycle %0d actual=frame required=idle", cyc);
          end else begin
            w = exp_q.pop_front();
            bq.delete();
            repeat (PB) bq.push_back(1'b1);
            bq.push_back(1'b0);
            for (int k = DW - 1; k >= 0; k--) bq.push_back(w[k]);
            if (PAR != 0) bq.push_back(1'($countones(w) % 2));
            exp_bits.delete();
            foreach (bq[i]) begin
              repeat (HC) exp_bits.push_back(bq[i]);
              repeat (HC) exp_bits.push_back(~bq[i]);
            end
            repeat (GAPC) exp_bits.push_back(1'b0);
            samp.delete();
            idx = 0; nmis = 0; first_bad = -1; done_bad = 0; rb_bad = 0;
            mon_active = 1'b1;
          end
        end
      end
      if (mon_active) begin
        samp.push_back(dataout);
        if (dataout !== exp_bits[idx]) begin
          nmis++;
          if (first_bad < 0) first_bad = idx;
        end
        if (tx_done !== (idx == TOTAL - 2)) done_bad++;
        if ({tx_ready, tx_busy} !== ((idx >= TOTAL - 1) ? 2'b10 : 2'b01)) rb_bad++;
        idx++;
        if (idx == TOTAL) begin
          for (int j = 0; j < DW; j++) dec[DW-1-j] = samp[(PB + 1 + j) * 2 * HC];
          if (nmis != 0) $display("  first line deviation at sample %0d of word %0h", first_bad, w);
          check("frame_line_mismatches", nmis, 0);
          check("frame_done_position", done_bad, 0);
          check("frame_ready_busy", rb_bad, 0);
          check("frame_decoded_word", dec, w);
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] w, input bit hold, output int hs);
    int n;
    n = 0;
    hs = -1;
    tx_data  = w;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 4 * TOTAL) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=not_ready required=ready");
        tx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    hs = cyc;
    exp_q.push_back(w);
    #1;
    check("busy_rise", {tx_busy, tx_ready}, 2'b10);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 || mon_active || tx_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 6 * TOTAL) begin
        checks++; errors++;
        $display("FAIL idle_timeout actual=busy required=idle");
        return;
      end
    end
  endtask

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : stimulus
    int hs1, hs2, gap;
    logic [DW-1:0] w;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {dataout, tx_busy, tx_done}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1'b1);

    send(8'hA5, 1'b0, hs1);
    wait_idle();
    send(8'hFF, 1'b0, hs1);
    wait_idle();

    // Held valid across the gap: second word accepted on the first IDLE cycle.
    send(8'h3C, 1'b1, hs1);
    send(8'hC3, 1'b0, hs2);
    check("back_to_back_spacing", hs2 - hs1, TOTAL + 1);
    wait_idle();

    // Data scrambled while busy, plus a stray valid pulse that must be dropped.
    send(8'h96, 1'b0, hs1);
    for (int i = 0; i < TOTAL + 4 && tx_busy === 1'b1; i++) begin
      @(negedge clk);
      tx_data  = DW'($urandom);
      tx_valid = (i == 10);
    end
    tx_valid = 1'b0;
    wait_idle();

    // Asynchronous abort mid-frame.
    send(8'h5A, 1'b0, hs1);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("abort_async_outputs", {dataout, tx_busy, tx_done}, 3'b000);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", tx_ready, 1'b1);
    send(8'h81, 1'b0, hs1);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      w   = DW'($urandom);
      gap = $urandom_range(0, 4);
      send(w, gap == 0, hs1);
      if (gap != 0) repeat (gap) @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle();
    repeat (2 * TOTAL) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
